// File: rtl/riscv_if_parcel_queue.sv
// Instruction-fetch parcel queue and aligner.
// Buffers fetched parcels in a circular FIFO and presents one aligned instruction
// per cycle: a single 16-bit RVC parcel or two consecutive parcels for a 32-bit
// instruction. The pair may straddle a fetch-word boundary.
//
// Handshake: an instruction moves to the consumer in a cycle where instr_valid_o
// and instr_rd_i are both high. instr_valid_o does not depend on instr_rd_i.
// Upstream may issue a fetch only while queue_rdy_o is high. Every return that can
// still be in flight is then guaranteed a slot.
module riscv_if_parcel_queue #(
   parameter int XLEN        = 32,
   parameter int PARCEL_SIZE = 16,
   parameter int HAS_RVC     = 0,
   parameter int DEPTH       = 8,
   parameter int INFLIGHT    = 2
) (
   input  logic                            clk_i,
   input  logic                            rst_ni,
   input  logic                            flush_i,
   input  logic [XLEN-1:0]                 parcel_pc_i,
   input  logic [XLEN-1:0]                 parcel_i,
   input  logic [XLEN/PARCEL_SIZE-1:0]     parcel_valid_i,
   input  logic                            parcel_error_i,
   output logic                            queue_rdy_o,
   output logic                            instr_valid_o,
   output logic [31:0]                     instr_o,
   output logic [XLEN-1:0]                 instr_pc_o,
   output logic                            instr_rvc_o,
   output logic                            instr_error_o,
   input  logic                            instr_rd_i
);

   localparam int PPW = XLEN / PARCEL_SIZE;
   localparam int AW  = $clog2(DEPTH);
   localparam int CW  = AW + 1;
   localparam int LW  = $clog2(PPW);
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
   localparam logic [CW-1:0] RDY_MIN = CW'((INFLIGHT + 1) * PPW);

   // Parcel storage. Only the pointers and the count carry reset state.
   logic [XLEN-1:0]        pc_mem     [DEPTH];
   logic [PARCEL_SIZE-1:0] parcel_mem [DEPTH];
   logic [DEPTH-1:0]       err_mem;

   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [CW-1:0] count;
   logic [CW-1:0] free;

   logic [CW-1:0] nwr;
   logic [CW-1:0] nwr_eff;
   logic [PPW-1:0] lane_we;
   logic [AW-1:0] lane_idx [PPW];
   logic [XLEN-1:0] lane_pc [PPW];

   logic [AW-1:0] h1_idx;
   logic          rvc;
   logic          need_one;
   logic [CW-1:0] need;
   logic [CW-1:0] nrd;

   assign free        = DEPTH_C - count;
   assign queue_rdy_o = free >= RDY_MIN;

   // Pack valid lanes in ascending order at consecutive slots. Drop lanes that do not fit.
   always_comb begin
      nwr     = '0;
      nwr_eff = '0;
      lane_we = '0;
      for (int k = 0; k < PPW; k++) begin
         lane_idx[k]        = wr_ptr + nwr_eff[AW-1:0];
         lane_pc[k]         = parcel_pc_i;
         lane_pc[k][LW:1]   = LW'(k);
         if (parcel_valid_i[k]) begin
            nwr = nwr + CW'(1);
            if (!flush_i && (nwr_eff < free)) begin
               lane_we[k] = 1'b1;
               nwr_eff    = nwr_eff + CW'(1);
            end
         end
      end
   end

   // Head decode. A head error is reported alone, so a bad fetch never waits on a second parcel.
   always_comb begin
      h1_idx        = rd_ptr + AW'(1);
      rvc           = (HAS_RVC != 0) && (parcel_mem[rd_ptr][1:0] != 2'b11);
      need_one      = rvc || err_mem[rd_ptr];
      need          = need_one ? CW'(1) : CW'(2);
      instr_valid_o = (count >= need) && !flush_i;
      instr_o       = need_one ? {{(32-PARCEL_SIZE){1'b0}}, parcel_mem[rd_ptr]}
                               : {parcel_mem[h1_idx], parcel_mem[rd_ptr]};
      instr_pc_o    = pc_mem[rd_ptr];
      instr_rvc_o   = rvc;
      instr_error_o = ((count != '0) && err_mem[rd_ptr])
                    || (!need_one && (count >= CW'(2)) && err_mem[h1_idx]);
      nrd           = (instr_valid_o && instr_rd_i) ? need : '0;
   end

   // Pointer and occupancy update. A flush discards any same-cycle read and write.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush_i) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         wr_ptr <= wr_ptr + nwr_eff[AW-1:0];
         rd_ptr <= rd_ptr + nrd[AW-1:0];
         count  <= count + nwr_eff - nrd;
      end
   end

   // Store the accepted lanes with their lane-adjusted pc and the fetch error flag.
   always_ff @(posedge clk_i) begin
      for (int k = 0; k < PPW; k++) begin
         if (lane_we[k]) begin
            pc_mem[lane_idx[k]]     <= lane_pc[k];
            parcel_mem[lane_idx[k]] <= parcel_i[k*PARCEL_SIZE +: PARCEL_SIZE];
            err_mem[lane_idx[k]]    <= parcel_error_i;
         end
      end
   end

   // Upstream must never deliver more parcels than there is free space for.
   overflow_a: assert property (@(posedge clk_i) disable iff (!rst_ni) flush_i || (nwr <= free));

endmodule

// File: tb/tb_riscv_if_parcel_queue.sv
// Bench for riscv_if_parcel_queue (HAS_RVC=1, DEPTH=8, INFLIGHT=2).
// The bench uses a directed vector table plus hand-written sequences:
// back-to-back traffic across the pointer wrap, and reset asserted mid-operation.
module tb_riscv_if_parcel_queue;

   logic        clk;
   logic        rst_n;
   logic        flush;
   logic [31:0] parcel_pc;
   logic [31:0] parcel;
   logic [1:0]  parcel_valid;
   logic        parcel_error;
   logic        queue_rdy;
   logic        instr_valid;
   logic [31:0] instr;
   logic [31:0] instr_pc;
   logic        instr_rvc;
   logic        instr_error;
   logic        instr_rd;

   int checks = 0;
   int errors = 0;

   riscv_if_parcel_queue #(
      .XLEN(32), .PARCEL_SIZE(16), .HAS_RVC(1), .DEPTH(8), .INFLIGHT(2)
   ) dut (
      .clk_i          (clk),
      .rst_ni         (rst_n),
      .flush_i        (flush),
      .parcel_pc_i    (parcel_pc),
      .parcel_i       (parcel),
      .parcel_valid_i (parcel_valid),
      .parcel_error_i (parcel_error),
      .queue_rdy_o    (queue_rdy),
      .instr_valid_o  (instr_valid),
      .instr_o        (instr),
      .instr_pc_o     (instr_pc),
      .instr_rvc_o    (instr_rvc),
      .instr_error_o  (instr_error),
      .instr_rd_i     (instr_rd)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   typedef struct {
      logic        flush;
      logic [31:0] pc;
      logic [31:0] word;
      logic [1:0]  vld;
      logic        err;
      logic        rd;
      logic        e_valid;
      logic [31:0] e_instr;
      logic [31:0] e_pc;
      logic        e_rvc;
      logic        e_err;
      logic        chk_err;
      logic        e_rdy;
   } vec_t;

   localparam int NV = 25;
   vec_t vecs [NV];

   function automatic vec_t mk(input logic fl, input logic [31:0] pc, input logic [31:0] word,
                               input logic [1:0] vld, input logic err, input logic rd,
                               input logic ev, input logic [31:0] ei, input logic [31:0] ep,
                               input logic er, input logic ee, input logic ce, input logic ey);
      vec_t v;
      v.flush = fl; v.pc = pc; v.word = word; v.vld = vld; v.err = err; v.rd = rd;
      v.e_valid = ev; v.e_instr = ei; v.e_pc = ep; v.e_rvc = er; v.e_err = ee;
      v.chk_err = ce; v.e_rdy = ey;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // driver tasks
   task automatic drive_idle();
      flush = 1'b0; parcel_pc = '0; parcel = '0; parcel_valid = '0;
      parcel_error = 1'b0; instr_rd = 1'b0;
   endtask

   task automatic drive_vec(input vec_t v);
      flush = v.flush; parcel_pc = v.pc; parcel = v.word; parcel_valid = v.vld;
      parcel_error = v.err; instr_rd = v.rd;
   endtask

   // scoreboard for the wrap sequence: {pc, instr}
   logic [63:0] exp_q [$];

   initial begin
      int seen;
      logic [63:0] e;
      logic [31:0] w;

      drive_idle();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #2 rst_n = 1'b1;

      // {flush,pc,word,vld,err,rd,  e_valid,e_instr,e_pc,e_rvc,e_err,chk_err,e_rdy}
      vecs[0]  = mk(0, 32'h0,   32'h0,        2'b00, 0, 0,  0, 32'h0,        32'h0,   0, 0, 1, 1);
      vecs[1]  = mk(0, 32'h100, 32'h00A00093, 2'b11, 0, 0,  0, 32'h0,        32'h0,   0, 0, 1, 1);
      vecs[2]  = mk(0, 32'h0,   32'h0,        2'b00, 0, 1,  1, 32'h00A00093, 32'h100, 0, 0, 1, 1);
      vecs[3]  = mk(0, 32'h200, 32'h45054501, 2'b11, 0, 0,  0, 32'h0,        32'h0,   0, 0, 1, 1);
      vecs[4]  = mk(0, 32'h0,   32'h0,        2'b00, 0, 1,  1, 32'h00004501, 32'h200, 1, 0, 1, 1);
      vecs[5]  = mk(0, 32'h0,   32'h0,        2'b00, 0, 1,  1, 32'h00004505, 32'h202, 1, 0, 1, 1);
      vecs[6]  = mk(0, 32'h0,   32'h0,        2'b00, 0, 1,  0, 32'h0,        32'h0,   0, 0, 1, 1);
      vecs[7]  = mk(0, 32'h302, 32'h00931234, 2'b10, 0, 0,  0, 32'h0,        32'h0,   0, 0, 1, 1);
      vecs[8]  = mk(0, 32'h304, 32'h567800A0, 2'b11, 0, 0,  0, 32'h0,        32'h0,   0, 0, 1, 1);
      vecs[9]  = mk(0, 32'h0,   32'h0,        2'b00, 0, 1,  1, 32'h00A00093, 32'h302, 0, 0, 1, 0);
      vecs[10] = mk(0, 32'h0,   32'h0,        2'b00, 0, 1,  1, 32'h00005678, 32'h306, 1, 0, 1, 1);
      vecs[11] = mk(0, 32'h400, 32'h00130013, 2'b11, 0, 0,  0, 32'h0,        32'h0,   0, 0, 1, 1);
      vecs[12] = mk(0, 32'h404, 32'h00130000, 2'b10, 0, 0,  1, 32'h00130013, 32'h400, 0, 0, 1, 1);
      vecs[13] = mk(1, 32'h408, 32'hABCD0013, 2'b11, 0, 1,  0, 32'h0,        32'h0,   0, 0, 0, 0);
      vecs[14] = mk(0, 32'h0,   32'h0,        2'b00, 0, 0,  0, 32'h0,        32'h0,   0, 0, 1, 1);
      vecs[15] = mk(0, 32'h500, 32'h12370000, 2'b10, 1, 0,  0, 32'h0,        32'h0,   0, 0, 1, 1);
      vecs[16] = mk(0, 32'h0,   32'h0,        2'b00, 0, 1,  1, 32'h00001237, 32'h502, 0, 1, 1, 1);
      vecs[17] = mk(0, 32'h600, 32'h00B00113, 2'b11, 0, 0,  0, 32'h0,        32'h0,   0, 0, 1, 1);
      vecs[18] = mk(0, 32'h604, 32'h00C00193, 2'b11, 0, 0,  1, 32'h00B00113, 32'h600, 0, 0, 1, 1);
      vecs[19] = mk(0, 32'h0,   32'h0,        2'b00, 0, 1,  1, 32'h00B00113, 32'h600, 0, 0, 1, 0);
      vecs[20] = mk(0, 32'h0,   32'h0,        2'b00, 0, 0,  1, 32'h00C00193, 32'h604, 0, 0, 1, 1);
      vecs[21] = mk(0, 32'h608, 32'h00D00213, 2'b11, 0, 1,  1, 32'h00C00193, 32'h604, 0, 0, 1, 1);
      vecs[22] = mk(0, 32'h60C, 32'h00E00293, 2'b11, 0, 1,  1, 32'h00D00213, 32'h608, 0, 0, 1, 1);
      vecs[23] = mk(0, 32'h0,   32'h0,        2'b00, 0, 1,  1, 32'h00E00293, 32'h60C, 0, 0, 1, 1);
      vecs[24] = mk(0, 32'h0,   32'h0,        2'b00, 0, 1,  0, 32'h0,        32'h0,   0, 0, 1, 1);

      // table: drive just after the rising edge, compare on the falling edge
      for (int i = 0; i < NV; i++) begin
         @(posedge clk); #1;
         drive_vec(vecs[i]);
         @(negedge clk);
         chk($sformatf("row%0d valid", i), 32'(instr_valid), 32'(vecs[i].e_valid));
         chk($sformatf("row%0d rdy", i), 32'(queue_rdy), 32'(vecs[i].e_rdy));
         if (vecs[i].e_valid) begin
            chk($sformatf("row%0d instr", i), instr, vecs[i].e_instr);
            chk($sformatf("row%0d pc", i), instr_pc, vecs[i].e_pc);
            chk($sformatf("row%0d rvc", i), 32'(instr_rvc), 32'(vecs[i].e_rvc));
            chk($sformatf("row%0d err", i), 32'(instr_error), 32'(vecs[i].e_err));
         end else if (vecs[i].chk_err) begin
            chk($sformatf("row%0d err", i), 32'(instr_error), 32'(vecs[i].e_err));
         end
      end

      // back-to-back words with a consumer that always reads; pointers wrap several times
      seen = 0;
      for (int i = 0; i < 12; i++) begin
         @(posedge clk); #1;
         w = {16'h0100 + 16'(i), 16'h0013 + 16'(i << 4)};
         drive_idle();
         parcel_pc = 32'h700 + 32'(4 * i);
         parcel = w;
         parcel_valid = 2'b11;
         instr_rd = 1'b1;
         exp_q.push_back({32'h700 + 32'(4 * i), w});
         @(negedge clk);
         if (instr_valid) begin
            if (exp_q.size() > 1) begin
               e = exp_q.pop_front();
               chk($sformatf("wrap pc %0d", seen), instr_pc, e[63:32]);
               chk($sformatf("wrap instr %0d", seen), instr, e[31:0]);
               seen++;
            end else begin
               chk("wrap unexpected valid", 32'(instr_valid), 32'h0);
            end
         end
      end
      for (int c = 0; c < 10 && exp_q.size() != 0; c++) begin
         @(posedge clk); #1;
         drive_idle();
         instr_rd = 1'b1;
         @(negedge clk);
         if (instr_valid) begin
            e = exp_q.pop_front();
            chk($sformatf("wrap pc %0d", seen), instr_pc, e[63:32]);
            chk($sformatf("wrap instr %0d", seen), instr, e[31:0]);
            seen++;
         end
      end
      chk("wrap leftover", 32'(exp_q.size()), 32'h0);
      chk("wrap delivered", 32'(seen), 32'd12);

      // reset asserted mid-operation clears immediately
      @(posedge clk); #1;
      drive_idle();
      parcel_pc = 32'h800; parcel = 32'h00F00313; parcel_valid = 2'b11;
      @(posedge clk); #1;
      drive_idle();
      @(negedge clk);
      chk("pre-reset valid", 32'(instr_valid), 32'h1);
      chk("pre-reset instr", instr, 32'h00F00313);
      #2 rst_n = 1'b0;
      #1;
      chk("async reset valid", 32'(instr_valid), 32'h0);
      chk("async reset rdy", 32'(queue_rdy), 32'h1);
      chk("async reset err", 32'(instr_error), 32'h0);
      @(posedge clk); #1 rst_n = 1'b1;
      @(negedge clk);
      chk("post-reset valid", 32'(instr_valid), 32'h0);
      chk("post-reset rdy", 32'(queue_rdy), 32'h1);

      // final report
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
